pe_result_writer: RTL
=====================

// Module: pe_result_writer
// PURPOSE
//  Downstream of the PE array: collects finished per-PE results (data + output address), arbitrates
//  them round-robin, rescales/ReLUs/saturates each to a byte and queues it in a small FIFO that drains
//  to the single-port output memory. Sequenced by the main controller via start/flush; done pulses
//  when every accepted result has been written.
// PARAMETERS
//  N      4   number of PEs (requesters), N>=2
//  DW     20  signed PE result width
//  AW     32  output-memory address width
//  SHIFT  4   arithmetic right shift applied before ReLU/saturation (0..DW-1)
//  DEPTH  8   FIFO depth, power of two
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-low reset
//  start      in   1      pulse: begin a new output tile (IDLE->RUN), clears wr_count
//  flush      in   1      pulse: no more results this tile (RUN->DRAIN)
//  pe_valid   in   N      PE i offers a result
//  pe_data    in   N*DW   PE i result, slice [i*DW +: DW], signed
//  pe_addr    in   N*AW   PE i output address, slice [i*AW +: AW]
//  pe_ready   out  N      one-hot grant; transfer when pe_valid[i] & pe_ready[i]
//  mem_wr     out  1      write request to output memory
//  mem_addr   out  AW     write address
//  mem_data   out  8      write byte
//  mem_ready  in   1      memory accepts; write completes when mem_wr & mem_ready
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse on DRAIN->IDLE
//  wr_count   out  16     writes completed this tile, wraps at 2^16
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, FIFO empty, rr_ptr=N-1, pe_ready=0, mem_wr=0, mem_addr=0,
//   mem_data=0, busy=0, done=0, wr_count=0.
//  FSM: IDLE --start--> RUN --flush--> DRAIN --FIFO empty--> IDLE (done=1 that cycle).
//   start ignored outside IDLE; flush ignored outside RUN; start and flush same cycle in IDLE: start only.
//   flush with an empty FIFO: DRAIN lasts one cycle, then done.
//  Grant (RUN only, combinational): if FIFO not full, pe_ready = one-hot of first i with pe_valid[i],
//   searching rr_ptr+1, rr_ptr+2, ... mod N; else 0. pe_ready is 0 in IDLE and DRAIN.
//   On transfer rr_ptr <= granted index. A pop in the same cycle does NOT free a slot for push.
//  Arithmetic on the granted entry: s = pe_data >>> SHIFT (sign-extending); byte = (s<0) ? 0 :
//   (s>255) ? 255 : s[7:0]. Address passes through unchanged.
//  FIFO: push on transfer; pop on mem_wr & mem_ready; push and pop may occur in the same cycle.
//   mem_wr = !empty; mem_addr/mem_data = head entry (0 when empty). Result accepted at edge k appears
//   on the memory port after edge k (write can complete at edge k+1). mem_wr/mem_data/mem_addr must
//   stay stable while mem_ready=0. Order of writes equals order of acceptance.
//  Draining continues in RUN and DRAIN; FIFO is never empty-popped or full-pushed.
//  wr_count: +1 per completed write, cleared on accepted start.
//  Async reset mid-tile discards FIFO contents; no done pulse is produced.
// TESTING
//  1 Reset mid-DRAIN with 3 entries queued -> all outputs at reset values immediately, no done, mem_wr=0.
//  2 start; all 4 PEs valid continuously, mem_ready=1 -> grants cycle PE0,1,2,3,0...; one write/cycle;
//    first mem_wr one cycle after first grant.
//  3 SHIFT=4: pe_data=-100 -> 0; 0x00FF0 -> 0xFF; 0x01000 -> 0xFF (sat); 0x00A70 -> 0xA7.
//  4 mem_ready=0 for 20 cycles with PEs valid -> exactly DEPTH=8 accepted, pe_ready=0 after, mem outputs
//    stable; release -> 8 writes in acceptance order.
//  5 flush while 5 entries queued, mem_ready=1 -> pe_ready=0 from flush+1, 5 writes, done pulse
//    exactly 1 cycle, wr_count equals total accepted, busy=0 after.
//  6 flush with empty FIFO -> done 2 cycles after flush edge; start during DRAIN ignored.

Source files
------------

// File: rtl/pe_result_writer_if.sv
// PE result / output-memory handshake bundle for pe_result_writer.
// slave is the writer's view; master is the environment (PE array + memory) view.
interface pe_result_writer_if #(
   parameter int unsigned N  = 4,
   parameter int unsigned DW = 20,
   parameter int unsigned AW = 32
);
   logic [N-1:0]    pe_valid;
   logic [N*DW-1:0] pe_data;
   logic [N*AW-1:0] pe_addr;
   logic [N-1:0]    pe_ready;
   logic            mem_wr;
   logic [AW-1:0]   mem_addr;
   logic [7:0]      mem_data;
   logic            mem_ready;

   modport master (
      output pe_valid, pe_data, pe_addr, mem_ready,
      input  pe_ready, mem_wr, mem_addr, mem_data
   );

   modport slave (
      input  pe_valid, pe_data, pe_addr, mem_ready,
      output pe_ready, mem_wr, mem_addr, mem_data
   );
endinterface

// File: rtl/pe_result_writer.sv
// Round-robin collector of PE results: rescale, ReLU, saturate to a byte, then queue
// into a small FIFO that drains to the single-port output memory.
module pe_result_writer #(
   parameter int unsigned N     = 4,
   parameter int unsigned DW    = 20,
   parameter int unsigned AW    = 32,
   parameter int unsigned SHIFT = 4,
   parameter int unsigned DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                flush,
   pe_result_writer_if.slave   bus,
   output logic                busy,
   output logic                done,
   output logic [15:0]         wr_count
);
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned FW = $clog2(DEPTH);
   localparam int unsigned CW = FW + 1;
   localparam logic signed [DW-1:0] BYTE_MAX = DW'(255);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } entry_t;

   state_t               state, state_d;
   logic                 done_d;
   logic [PW-1:0]        rr_ptr, gnt_idx, cand;
   logic                 gnt_found;
   logic [N-1:0]         grant;
   logic signed [DW-1:0] sel_data, scaled;
   logic [AW-1:0]        sel_addr;
   entry_t               push_entry;
   entry_t               fifo_mem [DEPTH];
   logic [FW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   logic                 empty, full, push, pop;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // Round-robin search starting after the last granted PE; full ignores a same-cycle pop
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      grant     = '0;
      if (state == RUN && !full) begin
         for (int unsigned k = 1; k <= N; k++) begin
            cand = PW'((32'(rr_ptr) + k) % N);
            if (!gnt_found && bus.pe_valid[cand]) begin
               gnt_found = 1'b1;
               gnt_idx   = cand;
            end
         end
      end
      if (gnt_found) grant[gnt_idx] = 1'b1;
   end

   assign bus.pe_ready = grant;
   assign push         = gnt_found;
   assign pop          = !empty && bus.mem_ready;

   // Rescale the granted result and clamp it into an unsigned byte
   always_comb begin
      sel_data        = $signed(bus.pe_data[32'(gnt_idx)*DW +: DW]);
      sel_addr        = bus.pe_addr[32'(gnt_idx)*AW +: AW];
      scaled          = sel_data >>> SHIFT;
      push_entry.addr = sel_addr;
      if (scaled[DW-1])            push_entry.data = 8'h00;
      else if (scaled > BYTE_MAX)  push_entry.data = 8'hFF;
      else                         push_entry.data = scaled[7:0];
   end

   // Storage is not reset: only entries between rd_ptr and wr_ptr are ever exposed
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rr_ptr <= PW'(N - 1);
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            rr_ptr <= gnt_idx;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign bus.mem_wr   = !empty;
   assign bus.mem_addr = empty ? '0    : fifo_mem[rd_ptr].addr;
   assign bus.mem_data = empty ? 8'h00 : fifo_mem[rd_ptr].data;

   // Tile sequencing
   always_comb begin
      state_d = state;
      done_d  = 1'b0;
      case (state)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (flush) state_d = DRAIN;
         DRAIN:   if (empty) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_count <= '0;
      end else begin
         state <= state_d;
         busy  <= (state_d != IDLE);
         done  <= done_d;
         if (state == IDLE && start) wr_count <= '0;
         else if (pop)               wr_count <= wr_count + 16'd1;
      end
   end
endmodule
